// File: rtl/str_reader_8b.sv
// Byte string buffer with valid/ready readout, optional trailing checksum byte.
// Define STR_READER_CHECKSUM_EN to append a mod-256 sum byte after the data.
module str_reader_8b #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic [3:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DMAX = 4'(DEPTH);

`ifdef STR_READER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, DONE, SUM} state_t;
  localparam bit CK = 1'b1;
  logic [7:0] sum;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  localparam bit CK = 1'b0;
`endif

  state_t     state;
  logic [7:0] mem [DEPTH];
  logic [3:0] idx;
  logic [3:0] idx_nxt;
  logic [3:0] ncnt;
  logic       wr_ok;
  logic       is_last;

  always_comb begin
    wr_ok   = (state == IDLE) && wr_en && (count < DMAX);
    ncnt    = count + {3'b000, wr_ok};
    idx_nxt = idx + 4'd1;
    is_last = (idx == count - 4'd1);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
`ifdef STR_READER_CHECKSUM_EN
      sum       <= '0;
`endif
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (wr_ok) begin
            mem[count[AW-1:0]] <= wr_data;
            count <= ncnt;
          end
          // a same-cycle write lands before readout begins
          if (start && ncnt != 4'd0) begin
            state     <= SEND;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= (count == 4'd0) ? wr_data : mem[0];
            out_last  <= !CK && (ncnt == 4'd1);
`ifdef STR_READER_CHECKSUM_EN
            sum       <= '0;
`endif
          end
        end
        SEND: begin
          if (out_ready) begin
            if (is_last) begin
`ifdef STR_READER_CHECKSUM_EN
              state    <= SUM;
              out_data <= sum + out_data;
              out_last <= 1'b1;
`else
              state     <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              count     <= '0;
`endif
            end else begin
              idx      <= idx_nxt;
              out_data <= mem[idx_nxt[AW-1:0]];
              out_last <= !CK && (idx_nxt == count - 4'd1);
`ifdef STR_READER_CHECKSUM_EN
              sum      <= sum + out_data;
`endif
            end
          end
        end
`ifdef STR_READER_CHECKSUM_EN
        SUM: begin
          if (out_ready) begin
            state     <= DONE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            count     <= '0;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_str_reader_8b.sv
// Scoreboard bench for str_reader_8b: expected bytes queued at start,
// popped and compared on every out_valid&out_ready handshake.
module tb_str_reader_8b;

  localparam int DEPTH = 8;
`ifdef STR_READER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [3:0] count;

  str_reader_8b #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .start    (start),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  logic exp_done = 1'b0;

  logic [8:0] exp_q [$];
  logic [7:0] mmem [DEPTH];
  int mcount = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      exp_done = 1'b0;
    end else begin
      chk("done", {31'd0, done}, {31'd0, exp_done});
      if (done) done_seen++;
      if (exp_done) chk("cnt_after_done", {28'd0, count}, 32'd0);
      if (!out_valid) chk("last_no_valid", {31'd0, out_last}, 32'd0);
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {23'd0, out_last, out_data}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          chk("data", {24'd0, out_data}, {24'd0, e[7:0]});
          chk("last", {31'd0, out_last}, {31'd0, e[8]});
          if (e[8]) exp_done = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [7:0] b);
    if (mcount < DEPTH) begin
      mmem[mcount] = b;
      mcount++;
    end
  endtask

  task automatic model_read();
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < mcount; i++) begin
      exp_q.push_back({(i == mcount - 1) && !CK, mmem[i]});
      s = s + mmem[i];
    end
    if (CK) exp_q.push_back({1'b1, s});
    mcount = 0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    model_write(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    model_read();
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int d0;
    d0 = done_seen;
    for (int i = 0; i < 300 && done_seen == d0; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("done_count", done_seen, d0 + 1);
    out_ready = 1'b0;
    step();
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);

    // three bytes, consumer always ready
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    chk("cnt3", {28'd0, count}, 32'd3);
    out_ready = 1'b1;
    do_start();
    wait_done(1'b0);
    chk("cnt_idle", {28'd0, count}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);

    // overflow: ninth byte dropped
    for (int i = 1; i <= 9; i++) write_byte(8'(i));
    chk("cnt_full", {28'd0, count}, DEPTH);
    out_ready = 1'b1;
    do_start();
    wait_done(1'b0);

    // backpressure holds the first byte
    write_byte(8'hA5);
    write_byte(8'h5A);
    out_ready = 1'b0;
    do_start();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {24'd0, out_data}, 32'hA5);
      step();
    end
    out_ready = 1'b1;
    wait_done(1'b0);

    // start on an empty buffer is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("empty_busy", {31'd0, busy}, 32'd0);
      chk("empty_valid", {31'd0, out_valid}, 32'd0);
      step();
    end

    // writes during readout are ignored
    write_byte(8'h44);
    write_byte(8'h55);
    out_ready = 1'b0;
    do_start();
    wr_en = 1'b1;
    wr_data = 8'h99;
    step();
    wr_en = 1'b0;
    chk("cnt_send_wr", {28'd0, count}, 32'd2);
    out_ready = 1'b1;
    wait_done(1'b0);

    // write and start together: new byte is part of the readout
    write_byte(8'h61);
    wr_en = 1'b1;
    wr_data = 8'h7E;
    start = 1'b1;
    model_write(8'h7E);
    model_read();
    step();
    wr_en = 1'b0;
    start = 1'b0;
    wait_done(1'b1);

    // random backpressure
    for (int i = 0; i < 6; i++) write_byte(8'($urandom));
    do_start();
    wait_done(1'b1);

    // reset aborts after one of three bytes
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    out_ready = 1'b0;
    do_start();
    out_ready = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    mcount = 0;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_data", {24'd0, out_data}, 32'd0);
    chk("abort_last", {31'd0, out_last}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_count", {28'd0, count}, 32'd0);
    step();
    step();

`ifdef STR_READER_CHECKSUM_EN
    write_byte(8'hF0);
    write_byte(8'h20);
    out_ready = 1'b1;
    do_start();
    wait_done(1'b0);
`endif

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/str_reader_8b.md
STR_READER_8B -- requirements
Module: str_reader_8b

Interface
REQ-001 Parameter DEPTH, default 8, number of 8-bit buffer entries (2..15).
REQ-002 clk  input  1  system clock; all state changes on posedge clk only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 wr_en  input  1  write strobe; appends wr_data to the buffer while IDLE.
REQ-005 wr_data  input  8  byte to append.
REQ-006 start  input  1  request to read out the buffered string; sampled in IDLE only.
REQ-007 out_ready  input  1  consumer accepts out_data this cycle.
REQ-008 out_valid  output  1  out_data holds a valid byte (registered).
REQ-009 out_data  output  8  current byte being read out (registered).
REQ-010 out_last  output  1  qualifies out_data as the final byte of the string (registered).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  single-cycle pulse after the final byte is accepted.
REQ-013 count  output  4  number of bytes currently stored, 0..DEPTH.

Function
REQ-014 The block SHALL have states IDLE, SEND, DONE, plus SUM when CHECKSUM_EN is defined.
REQ-015 In IDLE, wr_en=1 with count<DEPTH SHALL store wr_data at index count and increment count on the same edge.
REQ-016 wr_en=1 with count==DEPTH SHALL be ignored: no store, count unchanged, no wrap-around.
REQ-017 wr_en in any state other than IDLE SHALL be ignored.
REQ-018 start=1 in IDLE with count>0 SHALL move to SEND and, on the next cycle, present out_valid=1 and out_data=entry 0.
REQ-019 start=1 with count==0 SHALL be ignored: state stays IDLE, no done pulse.
REQ-020 If start and wr_en are both high in IDLE, the write SHALL be performed first, and readout SHALL include the new byte.
REQ-021 In SEND, out_data and out_valid SHALL hold stable until out_ready=1, and each out_valid&out_ready edge SHALL advance to the next entry.
REQ-022 Back-to-back acceptance SHALL sustain one byte per cycle, with no bubble between entries.
REQ-023 Without CHECKSUM_EN, out_last SHALL be 1 exactly while entry count-1 is presented.
REQ-024 After the last byte is accepted, the block SHALL go to DONE with out_valid=0, assert done for exactly one cycle, clear count to 0, and return to IDLE.
REQ-025 out_valid SHALL be 0 in IDLE and DONE, and out_last SHALL be 0 whenever out_valid is 0.
REQ-026 Buffer contents SHALL not be modified by readout.

Reset
REQ-027 reset=1 SHALL, at the next posedge clk and in any state, force IDLE, count=0, out_valid=0, out_data=0, out_last=0, done=0, busy=0, and clear all buffer entries to 0.
REQ-028 reset SHALL take priority over wr_en, start and out_ready in the same cycle.
REQ-029 A reset during SEND SHALL abort the transfer, with no done pulse.

Configuration
REQ-030 Macro STR_READER_CHECKSUM_EN, when defined, SHALL add state SUM after the last entry, presenting out_data = (sum of all stored entries) mod 256 with out_last=1 and the same valid/ready holding rules.
REQ-031 With STR_READER_CHECKSUM_EN defined, out_last SHALL be 0 on the data entries, and DONE SHALL follow acceptance of the checksum byte.
REQ-032 Without STR_READER_CHECKSUM_EN, no SUM state or sum logic SHALL exist, and behaviour SHALL be exactly REQ-023/REQ-024.

Verification
REQ-033 Write 0x11,0x22,0x33; start; out_ready=1 -> bytes 0x11,0x22,0x33 on consecutive cycles, out_last with 0x33, done 1 cycle later, count=0.
REQ-034 Write 9 bytes 0x01..0x09 with DEPTH=8 -> count=8, readout 0x01..0x08, 0x09 dropped.
REQ-035 Write 0xA5,0x5A; start; hold out_ready=0 for 5 cycles -> out_data stays 0xA5, out_valid stays 1; release -> 0xA5 then 0x5A.
REQ-036 start with count=0 -> busy stays 0, no out_valid, no done; wr_en during SEND -> count unchanged.
REQ-037 Assert reset mid-SEND after 1 of 3 bytes -> next cycle all outputs 0, count=0, no done pulse.
REQ-038 With STR_READER_CHECKSUM_EN: write 0xF0,0x20 -> output 0xF0,0x20,0x10, out_last only on 0x10.
